// File: rtl/bky_shift_engine_pkg.sv
// Shared definitions for the Buckeye config-chain shift engine.
//   - default chain geometry (chip count, bits per chip, shift-clock divider)
//   - sequencer state encoding
//   - popcount helper used to size a shift sequence from the chip mask
package bky_shift_engine_pkg;

  localparam int NCHIP_DEF   = 6;
  localparam int BPC_DEF     = 48;
  localparam int CLK_DIV_DEF = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Masks wider than 32 chips are not expected on one chain.
  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/bky_shift_engine_if.sv
// Handshake and chip-pin bundle of the shift engine.
//   master : data source / chip side (drives start, abort, mask, din, drtn)
//   slave  : the shift engine (drives din_rd, dout, dout_vld, dsnd, bclk, busy, done)
interface bky_shift_engine_if import bky_shift_engine_pkg::*; #(parameter int NCHIP = NCHIP_DEF);

  logic             start;
  logic             abort;
  logic [NCHIP-1:0] mask;
  logic             din;
  logic             din_rd;
  logic             dout;
  logic             dout_vld;
  logic [NCHIP-1:0] drtn;
  logic [NCHIP-1:0] dsnd;
  logic [NCHIP-1:0] bclk;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, mask, din, drtn,
    input  din_rd, dout, dout_vld, dsnd, bclk, busy, done
  );

  modport slave (
    input  start, abort, mask, din, drtn,
    output din_rd, dout, dout_vld, dsnd, bclk, busy, done
  );

endinterface

// File: rtl/bky_shift_engine_chain_mux.sv
// Combinational daisy-chain routing for the selected chips.
//   msk       : latched chip selection (never all-zero in use)
//   sdo       : serial bit currently presented by the engine
//   drtn      : per-chip serial return
//   dsnd      : per-chip serial input
//   chain_end : return of the highest selected chip
// The first selected chip takes sdo; each later selected chip takes the
// return of the selected chip below it. Unselected chips just see sdo
// (their BCLK is held low, so the value is harmless).
module bky_chain_mux import bky_shift_engine_pkg::*; #(
  parameter int NCHIP = NCHIP_DEF
) (
  input  logic [NCHIP-1:0] msk,
  input  logic             sdo,
  input  logic [NCHIP-1:0] drtn,
  output logic [NCHIP-1:0] dsnd,
  output logic             chain_end
);

  always_comb begin
    logic carry;
    carry = sdo;
    dsnd  = '0;
    for (int i = 0; i < NCHIP; i++) begin
      dsnd[i] = msk[i] ? carry : sdo;
      if (msk[i]) carry = drtn[i];
    end
    chain_end = carry;
  end

endmodule

// File: rtl/bky_shift_engine.sv
// Self-timed shift sequencer for a daisy chain of Buckeye amplifier config chips.
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of bky_shift_engine_if (start/abort/mask/din in,
//          din_rd/dout/dout_vld pull-and-return handshake, dsnd/bclk/drtn
//          chip pins, busy/done status)
// Each bit takes CLK_DIV cycles of BCLK low (DIN pulled on the first) and
// CLK_DIV cycles of BCLK high; the chain end is captured on the last high edge.
//
// state | meaning
// IDLE  | waiting for start; bclk low
// LO    | bclk low half-period; first cycle pulls the next DIN bit
// HI    | bclk high on selected chips; last cycle samples chain end
// FIN   | single cycle, done pulse, then back to IDLE
module bky_shift_engine import bky_shift_engine_pkg::*; #(
  parameter int NCHIP   = NCHIP_DEF,
  parameter int BPC     = BPC_DEF,
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input logic                    clk,
  input logic                    rst,
  bky_shift_engine_if.slave      bus
);

  localparam int CNT_W = $clog2(NCHIP * BPC + 1);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_TOP  = DIV_W'(CLK_DIV - 1);
  localparam logic [NCHIP-1:0] ALL_ONES = '1;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_nxt, nbits;
  logic [NCHIP-1:0] msk_r, mask_eff, bclk_d;
  logic             sdo, chain_end;
  logic             accept, sample;
  logic             din_rd_d, dout_vld_d, busy_d, done_d;

  assign mask_eff = (bus.mask == '0) ? ALL_ONES : bus.mask;
  assign accept   = (state == ST_IDLE) && bus.start && !bus.abort;
  // Chain end is captured at the falling BCLK edge, before the chips shift.
  assign sample   = (state == ST_HI) && (div_cnt == '0) && !bus.abort;

  bky_chain_mux #(.NCHIP(NCHIP)) u_chain_mux (
    .msk       (msk_r),
    .sdo       (sdo),
    .drtn      (bus.drtn),
    .dsnd      (bus.dsnd),
    .chain_end (chain_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      nbits        <= '0;
      msk_r        <= ALL_ONES;
      sdo          <= 1'b0;
      bus.din_rd   <= 1'b0;
      bus.dout     <= 1'b0;
      bus.dout_vld <= 1'b0;
      bus.bclk     <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      if (accept) begin
        msk_r <= mask_eff;
        nbits <= CNT_W'(popcount(32'(mask_eff)) * BPC);
      end
      if (bus.din_rd) sdo <= bus.din;
      if (sample) bus.dout <= chain_end;
      bus.din_rd   <= din_rd_d;
      bus.dout_vld <= dout_vld_d;
      bus.bclk     <= bclk_d;
      bus.busy     <= busy_d;
      bus.done     <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    if (bus.abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state_nxt = ST_LO;
            div_nxt   = DIV_TOP;
            bit_nxt   = '0;
          end
        end
        ST_LO: begin
          if (div_cnt == '0) begin
            state_nxt = ST_HI;
            div_nxt   = DIV_TOP;
          end else begin
            div_nxt = div_cnt - 1'b1;
          end
        end
        ST_HI: begin
          if (div_cnt == '0) begin
            bit_nxt   = bit_cnt + 1'b1;
            div_nxt   = DIV_TOP;
            state_nxt = (bit_nxt == nbits) ? ST_FIN : ST_LO;
          end else begin
            div_nxt = div_cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so bclk and the
  // strobes come straight from flops.
  always_comb begin
    din_rd_d   = (state_nxt == ST_LO) && (state != ST_LO);
    dout_vld_d = sample;
    busy_d     = (state_nxt != ST_IDLE);
    done_d     = (state_nxt == ST_FIN);
    bclk_d     = (state_nxt == ST_HI) ? msk_r : '0;
  end

endmodule

// File: tb/tb_bky_shift_engine.sv
module tb_bky_shift_engine;

  localparam int NCHIP   = 3;
  localparam int BPC     = 4;
  localparam int CLK_DIV = 2;
  localparam int MAXC    = 120;

  typedef struct {
    logic [2:0]  mask;
    logic [11:0] din_v;
    logic [11:0] init;
    logic [2:0]  eff;
    int          nb;
    int          done_c;
    logic [11:0] dout_v;
    logic [11:0] fin_v;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  bky_shift_engine_if #(.NCHIP(NCHIP)) bus ();

  bky_shift_engine #(.NCHIP(NCHIP), .BPC(BPC), .CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural chips: shift on the falling BCLK edge, return their MSB.
  logic [NCHIP-1:0][BPC-1:0] chip, chip_init;
  logic [NCHIP-1:0]          bclk_prev = '0;
  logic [NCHIP-1:0]          drtn_v;
  bit                        load_tog  = 1'b0;
  bit                        load_seen = 1'b0;

  always @(bus.bclk or load_tog) begin : chip_model
    logic [NCHIP-1:0][BPC-1:0] nx;
    nx = chip;
    if (load_tog != load_seen) begin
      nx = chip_init;
      load_seen = load_tog;
    end
    for (int i = 0; i < NCHIP; i++)
      if (bclk_prev[i] && !bus.bclk[i]) nx[i] = {chip[i][BPC-2:0], bus.dsnd[i]};
    bclk_prev = bus.bclk;
    chip = nx;
  end

  always_comb begin
    drtn_v = '0;
    for (int i = 0; i < NCHIP; i++) drtn_v[i] = chip[i][BPC-1];
  end
  assign bus.drtn = drtn_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_chips(input logic [11:0] v);
    chip_init = v;
    load_tog  = ~load_tog;
    #1;
  endtask

  // Reference: the selected chips form one long shift register (lowest
  // selected chip nearest the engine). Its prior contents come out MSB first,
  // and the DIN bits, sent MSB first, end up filling it.
  function automatic vec_t ref_vec(input logic [2:0] m, input logic [11:0] dv,
                                   input logic [11:0] init);
    vec_t v;
    int   sel[$];
    v.mask  = m;
    v.din_v = dv;
    v.init  = init;
    v.eff   = (m == 3'b000) ? 3'b111 : m;
    for (int i = 0; i < NCHIP; i++) if (v.eff[i]) sel.push_back(i);
    v.nb     = sel.size() * BPC;
    v.dout_v = '0;
    v.fin_v  = init;
    for (int s = 0; s < sel.size(); s++)
      for (int b = 0; b < BPC; b++) begin
        v.dout_v[s*BPC+b]      = init[sel[s]*BPC+b];
        v.fin_v[sel[s]*BPC+b]  = dv[s*BPC+b];
      end
    v.done_c = 1 + v.nb * 2 * CLK_DIV;
    return v;
  endfunction

  // Start a sequence and follow it cycle by cycle (cycle 1 = first after START edge).
  task automatic run_seq(input logic [2:0] m, input logic [11:0] dv, input int nb_drive,
                         input int abort_at, input int restart_at,
                         output int nrd, output int nvld, output logic [11:0] dvec,
                         output int done_c, output logic [NCHIP-1:0][7:0] pulses);
    logic [NCHIP-1:0] prev;
    nrd = 0; nvld = 0; dvec = '0; done_c = 0; pulses = '0;
    @(negedge clk);
    bus.mask  = m;
    bus.start = 1'b1;
    prev = bus.bclk;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      bus.start = (c == restart_at);
      if (c == restart_at) bus.mask = ~m;
      bus.abort = (c == abort_at);
      for (int i = 0; i < NCHIP; i++)
        if (bus.bclk[i] && !prev[i]) pulses[i] = pulses[i] + 8'd1;
      prev = bus.bclk;
      if (bus.din_rd) begin
        bus.din = (nrd < nb_drive) ? dv[nb_drive-1-nrd] : 1'b0;
        nrd++;
      end
      if (bus.dout_vld) begin
        dvec = {dvec[10:0], bus.dout};
        nvld++;
      end
      if (abort_at > 0 && c == abort_at + 1) begin
        check("abort_bclk", 32'(bus.bclk), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
      end
      if (bus.done) begin
        done_c = c;
        check("fin_bclk", 32'(bus.bclk), 32'd0);
        break;
      end
      if (abort_at > 0 && c >= abort_at + 20) break;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input int restart_at, input bit start_at_done);
    int nrd, nvld, done_c;
    logic [11:0] dvec;
    logic [NCHIP-1:0][7:0] pulses;
    load_chips(v.init);
    run_seq(v.mask, v.din_v, v.nb, 0, restart_at, nrd, nvld, dvec, done_c, pulses);
    check("din_rd_count", nrd, v.nb);
    check("dout_vld_count", nvld, v.nb);
    check("dout_seq", 32'(dvec), 32'(v.dout_v));
    check("done_cycle", done_c, v.done_c);
    check("chip_final", 32'(chip), 32'(v.fin_v));
    for (int i = 0; i < NCHIP; i++)
      check("bclk_pulses", 32'(pulses[i]), v.eff[i] ? v.nb : 0);
    if (start_at_done) begin
      bus.mask  = 3'b010;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("start_at_done_busy", 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    check("busy_after", 32'(bus.busy), 32'd0);
  endtask

  vec_t tbl[4];

  initial begin
    vec_t v;
    int nrd, nvld, done_c;
    logic [11:0] dvec;
    logic [NCHIP-1:0][7:0] pulses;

    tbl[0] = '{mask:3'b111, din_v:12'hA5C, init:12'h321, eff:3'b111, nb:12, done_c:49,
               dout_v:12'h321, fin_v:12'hA5C};
    tbl[1] = '{mask:3'b010, din_v:12'h009, init:12'h7BE, eff:3'b010, nb:4,  done_c:17,
               dout_v:12'h00B, fin_v:12'h79E};
    tbl[2] = '{mask:3'b000, din_v:12'h3C6, init:12'h5A1, eff:3'b111, nb:12, done_c:49,
               dout_v:12'h5A1, fin_v:12'h3C6};
    tbl[3] = '{mask:3'b101, din_v:12'h0D2, init:12'h6F8, eff:3'b101, nb:8,  done_c:33,
               dout_v:12'h068, fin_v:12'hDF2};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mask  = '0;
    bus.din   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bclk", 32'(bus.bclk), 32'd0);
    check("rst_din_rd", 32'(bus.din_rd), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sdo", 32'(bus.dsnd[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 4; t++) do_vec(tbl[t], 0, 1'b0);

    // Mask 101 stays latched: chip3 is fed from chip1, chip2 sees sdo.
    load_chips(12'h008);
    check("route_dsnd3_hi", 32'(bus.dsnd[2]), 32'd1);
    check("route_dsnd2_sdo", 32'(bus.dsnd[1]), 32'd0);
    load_chips(12'h080);
    check("route_dsnd3_lo", 32'(bus.dsnd[2]), 32'd0);

    for (int r = 0; r < 24; r++) begin
      v = ref_vec(3'($urandom_range(0, 7)), 12'($urandom), 12'($urandom));
      do_vec(v, 0, 1'b0);
    end

    // ABORT during the 5th HI phase (cycles 19-20 of a full-chain run).
    v = ref_vec(3'b111, 12'($urandom), 12'($urandom));
    load_chips(v.init);
    run_seq(v.mask, v.din_v, v.nb, 19, 0, nrd, nvld, dvec, done_c, pulses);
    check("abort_din_rd_count", nrd, 5);
    check("abort_dout_vld_count", nvld, 4);
    check("abort_no_done", done_c, 0);
    check("abort_partial_dout", 32'(dvec[3:0]), 32'(v.dout_v[11:8]));
    check("abort_bclk_pulses", 32'(pulses[0]), 32'd5);

    // START while busy ignored; START in the DONE cycle ignored.
    v = ref_vec(3'b111, 12'($urandom), 12'($urandom));
    do_vec(v, 6, 1'b1);

    // ABORT beats a simultaneous START.
    @(negedge clk);
    bus.mask  = 3'b111;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_over_start_busy", 32'(bus.busy), 32'd0);
    check("abort_over_start_rd", 32'(bus.din_rd), 32'd0);

    // Reset in the middle of a LO phase.
    @(negedge clk);
    bus.mask  = 3'b111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("midlo_din_rd", 32'(bus.din_rd), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_bclk", 32'(bus.bclk), 32'd0);
    check("arst_din_rd", 32'(bus.din_rd), 32'd0);
    check("arst_dout", 32'(bus.dout), 32'd0);
    check("arst_dout_vld", 32'(bus.dout_vld), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = ref_vec(3'($urandom_range(0, 7)), 12'($urandom), 12'($urandom));
    do_vec(v, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
